fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: pc_write  in  1  from hazard unit; 0 holds PC.
REQ-005 Port: ifid_write  in  1  from hazard unit; 0 holds the IF/ID register.
REQ-006 Port: branch_taken  in  1  redirect request from branch resolution.
REQ-007 Port: branch_target  in  32  redirect address; bits [1:0] ignored and forced to 0.
REQ-008 Port: imem_req  out  1  fetch request to instruction memory.
REQ-009 Port: imem_addr  out  32  fetch address, equal to the current PC.
REQ-010 Port: imem_ready  in  1  memory has valid imem_rdata this cycle.
REQ-011 Port: imem_rdata  in  32  fetched instruction.
REQ-012 Port: ifid_instr  out  32  IF/ID instruction, feeding the ID-stage main control opcode decode.
REQ-013 Port: ifid_pc4  out  32  IF/ID PC+4.
REQ-014 Port: ifid_valid  out  1  IF/ID holds a real instruction, not a bubble.
REQ-015 Port: stall_count  out  32  count of stall and memory-wait cycles.
REQ-016 Port: flush_count  out  32  count of IF/ID flushes.

Function
REQ-017 The FSM SHALL have states FETCH and WAIT. FETCH->WAIT when imem_ready=0. WAIT->FETCH when imem_ready=1 or branch_taken=1.
REQ-018 imem_req SHALL be 1 in every non-reset cycle; imem_addr SHALL be driven combinationally from the PC register.
REQ-019 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0, except on a redirect.
REQ-020 Normal cycle (imem_ready=1, pc_write=1, ifid_write=1, no branch): PC<=PC+4; IF/ID<={imem_rdata, PC+4, valid=1}.
REQ-021 PC+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-022 When pc_write=0, PC SHALL hold. When ifid_write=0, IF/ID SHALL hold all fields, including ifid_valid.
REQ-023 When imem_ready=0, with no branch and both write enables high: PC SHALL hold and IF/ID SHALL load a bubble {32'h0000_0000, PC+4, valid=0}.
REQ-024 Priority, highest first: reset > branch_taken > ifid_write/pc_write stall > imem_ready wait.
REQ-025 Redirect: branch_taken=1 SHALL set PC<={branch_target[31:2],2'b00} regardless of pc_write, imem_ready or FSM state. The FSM SHALL go to FETCH, abandoning any outstanding fetch.
REQ-026 stall_count SHALL increment in each non-reset cycle with branch_taken=0 and (pc_write=0 or imem_ready=0), and SHALL saturate at 32'hFFFF_FFFF.
REQ-027 flush_count SHALL increment on every redirect that flushes IF/ID, saturating; without the flush feature it SHALL stay 0.
REQ-028 All outputs SHALL be registered except imem_req and imem_addr.

Reset
REQ-029 On reset: PC=RESET_PC, FSM=FETCH, ifid_instr=0, ifid_pc4=0, ifid_valid=0, stall_count=0, flush_count=0, imem_req=0.
REQ-030 Reset mid-WAIT SHALL abandon the fetch. The first post-reset fetch address SHALL be RESET_PC.

Configuration
REQ-031 Macro IFID_FLUSH_EN. Defined: a redirect SHALL load an IF/ID bubble {0, PC+4, valid=0} and increment flush_count.
REQ-032 IFID_FLUSH_EN undefined (branch delay slot): on a redirect, IF/ID SHALL follow REQ-020/022/023 as if no branch occurred; only the PC is redirected.

Structure
REQ-033 NOP_INSTR (32'h0000_0000) and the default RESET_PC SHALL live in the shared constants header alongside the opcode constants.
REQ-034 The IF/ID register (load, hold, bubble) SHALL be a sub-module named ifid_reg; the PC, FSM and counters stay in fetch_stage.

Verification
REQ-035 Reset, then imem_ready=1 for 4 cycles -> imem_addr 0,4,8,12; ifid_valid=1; ifid_pc4 4,8,12.
REQ-036 pc_write=ifid_write=0 for 2 cycles at PC=8 -> PC stays 8, IF/ID unchanged, stall_count=2.
REQ-037 imem_ready=0 for 3 cycles at PC=16 -> imem_addr stays 16, ifid_valid=0, stall_count=3; on ready=1, ifid_instr=imem_rdata.
REQ-038 branch_taken=1, target 32'h0000_0103, in WAIT with pc_write=0 -> next imem_addr=32'h0000_0100. With IFID_FLUSH_EN: ifid_valid=0 and flush_count=1. Without it: flush_count=0.
REQ-039 PC=32'hFFFF_FFFC with ready=1 -> next imem_addr=0 and ifid_pc4=0.
REQ-040 Reset asserted during WAIT -> next cycle all outputs at reset values; the fetch then restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage: NOP encoding,
// default reset PC, base opcode constants, FSM states and the IF/ID record.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr,
  input  logic [31:0] pc4,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  ifid_t r;

  always_ff @(posedge clock) begin
    if (reset) begin
      r <= '0;
    end else if (bubble) begin
      r <= '{instr: NOP_INSTR, pc4: pc4, valid: 1'b0};
    end else if (load) begin
      r <= '{instr: instr, pc4: pc4, valid: 1'b1};
    end
  end

  assign ifid_instr = r.instr;
  assign ifid_pc4   = r.pc4;
  assign ifid_valid = r.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, fetch FSM, stall/flush counters, IF/ID register.
// Define IFID_FLUSH_EN to flush IF/ID on redirect; otherwise a branch delay slot remains.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        ifid_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4;
  logic         stall_evt;
  logic         flush;
  logic         ifid_load, ifid_bubble;
  logic [1:0]   unused_tgt_lsbs;

  assign unused_tgt_lsbs = branch_target[1:0];
  assign pc_plus4        = pc + 32'd4;
  assign imem_req        = ~reset;
  assign imem_addr       = pc;

`ifdef IFID_FLUSH_EN
  assign flush = branch_taken;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (!branch_taken && !imem_ready) state_next = WAIT;
      WAIT:  if (branch_taken || imem_ready)   state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Redirect wins over every hold reason; otherwise advance only on a completed fetch.
  always_comb begin
    pc_next = pc;
    if (branch_taken)
      pc_next = {branch_target[31:2], 2'b00};
    else if (pc_write && imem_ready)
      pc_next = pc_plus4;
  end

  assign stall_evt   = !branch_taken && (!pc_write || !imem_ready);
  assign ifid_load   = ifid_write && imem_ready;
  assign ifid_bubble = flush || (ifid_write && !imem_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      stall_count <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (stall_evt && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end

`ifdef IFID_FLUSH_EN
  always_ff @(posedge clock) begin
    if (reset)
      flush_count <= '0;
    else if (flush && flush_count != '1)
      flush_count <= flush_count + 32'd1;
  end
`else
  always_ff @(posedge clock) begin
    flush_count <= '0;
  end
`endif

  ifid_reg u_ifid_reg (
    .clock      (clock),
    .reset      (reset),
    .load       (ifid_load),
    .bubble     (ifid_bubble),
    .instr      (imem_rdata),
    .pc4        (pc_plus4),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage; expectations follow IFID_FLUSH_EN.
module tb_fetch_stage;

`ifdef IFID_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, pc_write, ifid_write, branch_taken, imem_ready;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, ifid_instr, ifid_pc4, stall_count, flush_count;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .ifid_instr   (ifid_instr),
    .ifid_pc4     (ifid_pc4),
    .ifid_valid   (ifid_valid),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, pw, iw, br, rdy;
    logic [31:0] tgt, rdata;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_valid;
    logic [31:0] e_stall, e_flush;
    logic        e_req;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_miss = 0;

  localparam logic [31:0] A0 = 32'h0000_0013, A1 = 32'h0010_0093, A2 = 32'h0020_0113,
                          A3 = 32'h0030_0193, A4 = 32'h0040_0213, A5 = 32'h0050_0293,
                          A6 = 32'h0060_0313, A7 = 32'h0070_0393, A8 = 32'h0080_0413,
                          A9 = 32'h0090_0493, JK = 32'hDEAD_BEEF;

  task automatic add(input logic rst, pw, iw, br, input logic [31:0] tgt,
                     input logic rdy, input logic [31:0] rdata,
                     input logic [31:0] e_addr, e_instr, e_pc4, input logic e_valid,
                     input logic [31:0] e_stall, e_flush, input logic e_req);
    vec_t v;
    v.rst = rst; v.pw = pw; v.iw = iw; v.br = br; v.tgt = tgt; v.rdy = rdy; v.rdata = rdata;
    v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_req = e_req;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, pw, iw, br, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] rdata);
    reset = rst; pc_write = pw; ifid_write = iw; branch_taken = br;
    branch_target = tgt; imem_ready = rdy; imem_rdata = rdata;
  endtask

  initial begin
    drive(1, 1, 1, 0, 0, 1, 0);
    //  rst pw iw br tgt           rdy rdata   addr          instr         pc4           v      stall  flush          req
    add(1, 1, 1, 0, 32'h0,         1, JK,     32'h0,        32'h0,        32'h0,        0,     0,     0,             0); // 0 reset
    add(0, 1, 1, 0, 32'h0,         1, A0,     32'h4,        A0,           32'h4,        1,     0,     0,             1);
    add(0, 1, 1, 0, 32'h0,         1, A1,     32'h8,        A1,           32'h8,        1,     0,     0,             1);
    add(0, 0, 0, 0, 32'h0,         1, JK,     32'h8,        A1,           32'h8,        1,     1,     0,             1); // stall
    add(0, 0, 0, 0, 32'h0,         1, JK,     32'h8,        A1,           32'h8,        1,     2,     0,             1);
    add(0, 1, 1, 0, 32'h0,         1, A2,     32'hC,        A2,           32'hC,        1,     2,     0,             1);
    add(0, 1, 1, 0, 32'h0,         1, A3,     32'h10,       A3,           32'h10,       1,     2,     0,             1);
    add(0, 1, 1, 0, 32'h0,         0, JK,     32'h10,       32'h0,        32'h14,       0,     3,     0,             1); // wait
    add(0, 1, 1, 0, 32'h0,         0, JK,     32'h10,       32'h0,        32'h14,       0,     4,     0,             1);
    add(0, 1, 1, 0, 32'h0,         0, JK,     32'h10,       32'h0,        32'h14,       0,     5,     0,             1);
    add(0, 1, 1, 0, 32'h0,         1, A4,     32'h14,       A4,           32'h14,       1,     5,     0,             1);
    add(0, 1, 1, 0, 32'h0,         0, JK,     32'h14,       32'h0,        32'h18,       0,     6,     0,             1);
    add(0, 0, 1, 1, 32'h103,       0, JK,     32'h100,      32'h0,        32'h18,       0,     6,     FL ? 1 : 0,    1); // redirect in WAIT
    add(0, 1, 1, 0, 32'h0,         1, A5,     32'h104,      A5,           32'h104,      1,     6,     FL ? 1 : 0,    1);
    add(0, 1, 1, 1, 32'hFFFF_FFFE, 1, A6,     32'hFFFF_FFFC, FL ? 0 : A6, 32'h108,      !FL,   6,     FL ? 2 : 0,    1);
    add(0, 1, 1, 0, 32'h0,         1, A7,     32'h0,        A7,           32'h0,        1,     6,     FL ? 2 : 0,    1); // wrap
    add(0, 1, 0, 1, 32'h40,        1, JK,     32'h40,       FL ? 0 : A7,  FL ? 4 : 0,   !FL,   6,     FL ? 3 : 0,    1);
    add(0, 1, 0, 0, 32'h0,         0, JK,     32'h40,       FL ? 0 : A7,  FL ? 4 : 0,   !FL,   7,     FL ? 3 : 0,    1);
    add(1, 1, 1, 0, 32'h0,         0, JK,     32'h0,        32'h0,        32'h0,        0,     0,     0,             0); // reset in WAIT
    add(0, 1, 1, 0, 32'h0,         1, A8,     32'h4,        A8,           32'h4,        1,     0,     0,             1);
    add(0, 0, 1, 0, 32'h0,         1, A9,     32'h4,        A9,           32'h8,        1,     1,     0,             1);
    add(0, 1, 0, 0, 32'h0,         1, JK,     32'h8,        A9,           32'h8,        1,     1,     0,             1);

    @(negedge clock);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].pw, tbl[i].iw, tbl[i].br, tbl[i].tgt, tbl[i].rdy, tbl[i].rdata);
      @(posedge clock);
      #1;
      n_vec++;
      chk("imem_addr",   i, imem_addr,   tbl[i].e_addr);
      chk("ifid_instr",  i, ifid_instr,  tbl[i].e_instr);
      chk("ifid_pc4",    i, ifid_pc4,    tbl[i].e_pc4);
      chk("ifid_valid",  i, {31'b0, ifid_valid}, {31'b0, tbl[i].e_valid});
      chk("stall_count", i, stall_count, tbl[i].e_stall);
      chk("flush_count", i, flush_count, tbl[i].e_flush);
      chk("imem_req",    i, {31'b0, imem_req},   {31'b0, tbl[i].e_req});
    end

    // Hand sequence: imem_req drops combinationally in reset; address stable over a long wait.
    drive(1, 1, 1, 0, 0, 1, JK);
    #1;
    n_vec++;
    chk("req_in_reset", 100, {31'b0, imem_req}, 32'h0);
    @(posedge clock);
    #1;
    drive(0, 1, 1, 0, 0, 0, JK);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      n_vec++;
      chk("wait_addr",  101 + c, imem_addr, 32'h0);
      chk("wait_req",   101 + c, {31'b0, imem_req}, 32'h1);
      chk("wait_stall", 101 + c, stall_count, 32'(c + 1));
    end
    drive(0, 1, 1, 0, 0, 1, A3);
    @(posedge clock);
    #1;
    n_vec++;
    chk("resume_addr",  104, imem_addr,  32'h4);
    chk("resume_instr", 104, ifid_instr, A3);
    chk("resume_valid", 104, {31'b0, ifid_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
